pipe_reg_chain: RTL and testbench
=================================

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data bits per stage.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning the number of register stages; legal range is 1..16.
REQ-003 The block SHALL have parameter RESET_VAL, default 0, meaning the WIDTH-bit value loaded into every stage data register on reset or flush.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port enable, input, 1 bit: global advance enable; 0 freezes the chain.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous clear of all stage valids.
REQ-008 The block SHALL have port in_valid, input, 1 bit: upstream offers in_data.
REQ-009 The block SHALL have port in_data, input, WIDTH bits: upstream payload.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the chain accepts in_data this cycle.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the last stage holds valid data.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: last-stage payload.
REQ-013 The block SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-014 The block SHALL have port occupancy, output, $clog2(DEPTH+1) bits: the count of valid stages.

Function
REQ-015 Each stage i SHALL hold data_i and valid_i; stage 0 is the input side and stage DEPTH-1 drives out_data.
REQ-016 Stage i SHALL advance when enable=1, flush=0, and either valid_i=0 or stage i+1 advances; for the last stage, "stage i+1 advances" means out_ready=1.
REQ-017 in_ready SHALL equal the advance condition of stage 0, computed combinationally so that a full chain sustains one transfer per cycle.
REQ-018 out_valid SHALL equal valid_(DEPTH-1) AND enable AND NOT flush; out_data SHALL equal data_(DEPTH-1) unconditionally.
REQ-019 An advancing stage SHALL load data and valid from the previous stage, or from in_data and in_valid for stage 0; a non-advancing stage SHALL hold its data and valid.
REQ-020 A bubble SHALL advance with valid=0 and SHALL not alter the data register, to save toggles.
REQ-021 Latency SHALL be exactly DEPTH cycles: a word accepted at edge t SHALL present out_valid=1 after edge t+DEPTH-1 when the chain is unobstructed.
REQ-022 A transfer SHALL occur on the input side only when in_valid and in_ready are both 1, and on the output side only when out_valid and out_ready are both 1; nothing is dropped or duplicated under backpressure.
REQ-023 When flush=1, the next edge SHALL clear all valid_i to 0 and set all data_i to RESET_VAL; in_ready and out_valid SHALL be 0 in that cycle, so in_valid is not accepted.
REQ-024 When enable=0, all state SHALL hold; in_ready and out_valid SHALL be 0.
REQ-025 Priority SHALL be reset > flush > enable.
REQ-026 occupancy SHALL be a registered population count of valid_i, updated on the same edge as the valids; its range is 0..DEPTH.
REQ-027 With simultaneous input and output transfers on a full chain, occupancy SHALL remain DEPTH.

Reset
REQ-028 When reset=0 at a rising edge, all valid_i SHALL become 0, all data_i SHALL become RESET_VAL, and occupancy SHALL become 0.
REQ-029 Outputs after reset SHALL be in_ready=enable, out_valid=0, and out_data=RESET_VAL.
REQ-030 Reset asserted mid-stream SHALL discard all in-flight words with no partial output.
REQ-031 There SHALL be no initial blocks relied on for function.

Structure
REQ-032 A shared package SHALL hold the DEPTH limit constant (16) and an occupancy-width function (clog2).
REQ-033 The block SHALL contain one sub-module, pipe_reg_stage, holding data+valid and its hold/load/clear logic, instantiated DEPTH times by a generate loop.
REQ-034 Elaboration SHALL fail (assertion) for DEPTH outside 1..16.

Verification
REQ-035 Stream test: DEPTH=3, WIDTH=8, out_ready=1, inputs 0x01..0x05 on consecutive cycles -> outputs 0x01..0x05 on consecutive cycles, first one 3 cycles after acceptance; occupancy peaks at 3.
REQ-036 Backpressure test: fill DEPTH=3 with 0xA1,0xA2,0xA3, then out_ready=0 for 4 cycles -> in_ready=0, occupancy=3; release -> A1,A2,A3 in order with none lost.
REQ-037 Bubble test: input pattern valid,gap,valid (0x11,-,0x22) -> output shows 0x11, one invalid cycle, then 0x22.
REQ-038 Flush test: chain holding 2 words with in_valid=1 and flush pulsed for 1 cycle -> next cycle occupancy=0, out_valid=0, the offered word is not accepted, and out_data=RESET_VAL.
REQ-039 Enable test: enable=0 for 3 cycles mid-stream -> in_ready=0, out_valid=0, state unchanged; resume -> order and count preserved.
REQ-040 Reset test: reset=0 with a full chain, asserted coincident with flush and enable -> all valids cleared, out_data=RESET_VAL, and occupancy=0 on the next cycle.

Source files
------------

// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the pipe_reg_chain register pipeline.
package pipe_reg_chain_pkg;

    localparam int DEPTH_MAX = 16;

    // Occupancy counts 0..depth inclusive, so it needs clog2(depth+1) bits.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Valid/ready stream bundle for pipe_reg_chain, including the occupancy readout.
interface pipe_reg_chain_if
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);

    localparam int OCC_W = occ_width(DEPTH);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy
    );

endinterface

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: data+valid registers with clear, load and hold.
module pipe_reg_stage #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_advance,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    // Bubbles move the valid bit only; the data register keeps its old value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_advance) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= i_data;
            end else begin
                r_data <= r_data;
            end
        end else begin
            r_valid <= r_valid;
            r_data  <= r_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline of DEPTH stages with valid/ready flow control,
// bubble collapsing, flush, global enable and a registered occupancy count.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    flush,
    pipe_reg_chain_if.slave         bus
);

    localparam int OCC_W = occ_width(DEPTH);

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_depth_check
        $fatal(1, "pipe_reg_chain: DEPTH must be within 1..16");
    end

    logic [DEPTH-1:0]            w_valid;
    logic [DEPTH-1:0][WIDTH-1:0] w_data;
    logic [DEPTH-1:0]            w_prev_valid;
    logic [DEPTH-1:0][WIDTH-1:0] w_prev_data;
    logic [DEPTH-1:0]            w_adv;
    logic                        w_hole;
    logic                        w_in_xfer;
    logic                        w_out_xfer;
    logic [OCC_W-1:0]            r_occ;

    // A stage advances if any stage from it to the output is empty or the
    // sink is ready; the unrolled form keeps the ready path free of loops.
    always_comb begin
        w_hole = 1'b0;
        w_adv  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_hole   = w_hole | ~w_valid[i];
            w_adv[i] = enable & ~flush & (w_hole | bus.out_ready);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_prev_valid[g] = bus.in_valid;
            assign w_prev_data[g]  = bus.in_data;
        end else begin : g_body
            assign w_prev_valid[g] = w_valid[g-1];
            assign w_prev_data[g]  = w_data[g-1];
        end

        pipe_reg_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .i_advance (w_adv[g]),
            .i_flush   (flush),
            .i_valid   (w_prev_valid[g]),
            .i_data    (w_prev_data[g]),
            .o_valid   (w_valid[g]),
            .o_data    (w_data[g])
        );
    end

    assign w_in_xfer  = bus.in_valid & w_adv[0];
    assign w_out_xfer = bus.out_valid & bus.out_ready;

    // Occupancy tracks the valid population: +1 per accepted word, -1 per delivered word.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
        end
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_valid = w_valid[DEPTH-1] & enable & ~flush;
    assign bus.out_data  = w_data[DEPTH-1];
    assign bus.occupancy = r_occ;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomized and directed bench for pipe_reg_chain against a slot-level reference model.
module tb_pipe_reg_chain;

    localparam int         W  = 8;
    localparam int         D  = 3;
    localparam logic [7:0] RV = 8'h5A;

    logic clk = 1'b0;
    logic reset;
    logic enable;
    logic flush;

    pipe_reg_chain_if #(.WIDTH(W), .DEPTH(D)) bus ();

    pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .flush  (flush),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int         n_total = 0;
    int         n_bad   = 0;
    bit         chk_en  = 1'b0;
    bit         last_acc;
    int         peak_occ;
    bit         m_v [D];
    logic [7:0] m_d [D];
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check outputs at the falling edge, advance the model.
    task automatic cyc(input bit rst_n, input bit en, input bit fl, input bit iv,
                       input logic [7:0] id, input bit ordy);
        bit  adv [D];
        bit  free;
        bit  exp_ov;
        int  pop;
        reset         = rst_n;
        enable        = en;
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        @(negedge clk);
        free = ordy;
        for (int i = D - 1; i >= 0; i--) begin
            adv[i] = en && !fl && (!m_v[i] || free);
            free   = adv[i];
        end
        exp_ov = m_v[D-1] && en && !fl;
        pop = 0;
        for (int i = 0; i < D; i++) pop += int'(m_v[i]);
        last_acc = iv && adv[0] && rst_n;
        if (chk_en) begin
            chk("in_ready",  32'(bus.in_ready),  32'(adv[0]));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
            chk("out_data",  32'(bus.out_data),  32'(m_d[D-1]));
            chk("occupancy", 32'(bus.occupancy), 32'(pop));
            if (int'(bus.occupancy) > peak_occ) peak_occ = int'(bus.occupancy);
        end
        if (!rst_n || fl) begin
            for (int i = 0; i < D; i++) begin
                m_v[i] = 1'b0;
                m_d[i] = RV;
            end
            exp_q.delete();
        end else begin
            if (exp_ov && ordy) begin
                if (exp_q.size() > 0) chk("sb_order", 32'(bus.out_data), 32'(exp_q.pop_front()));
                else chk("sb_spurious", 32'(exp_q.size()), 32'd1);
            end
            for (int i = D - 1; i >= 0; i--) begin
                if (adv[i]) begin
                    m_v[i] = (i == 0) ? iv : m_v[i-1];
                    if (m_v[i]) m_d[i] = (i == 0) ? id : m_d[i-1];
                end
            end
            if (iv && adv[0]) exp_q.push_back(id);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [7:0] k;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk_en = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // stream 0x01..0x05
        peak_occ = 0;
        for (int i = 1; i <= 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'(i), 1'b1);
        idle(5);
        chk("stream_peak", 32'(peak_occ), 32'd3);

        // backpressure
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hA2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b0);
        chk("bp_full", 32'(bus.occupancy), 32'd3);
        idle(5);

        // bubble
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1);
        idle(5);

        // flush with two words held and a word offered
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hB1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hB2, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("flush_data", 32'(bus.out_data), 32'(RV));
        idle(3);

        // enable low for three cycles mid-stream
        k = 8'hC0;
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, !(c >= 2 && c < 5), 1'b0, 1'b1, k, 1'b1);
            if (last_acc) k = k + 8'd1;
        end
        idle(5);
        chk("enable_count", 32'(k), 32'hC7);

        // reset with a full chain, coincident with flush and enable
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hD1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hD2, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hD3, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hEE, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1);
        chk("reset_occ", 32'(bus.occupancy), 32'd0);
        idle(2);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0,
                8'($urandom), $urandom_range(0, 3) != 0);
        end
        idle(8);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
